quad_speed_meter: RTL

Quadrature decoder and speed meter that consumes the A/B encoder pair produced by the team's speed/quadrature generator, or by a real encoder. It synchronises A/B and decodes x4 edges into a signed position count and a direction flag. It also measures the clock-cycle interval between consecutive same-direction edges, and flags stall and illegal-transition conditions. Its outputs feed the speed/position control loop.

---
 rtl/quad_speed_meter_if.sv | 25 ++
 rtl/quad_speed_meter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/quad_speed_meter_if.sv
// Encoder-side inputs and position/speed outputs of the quadrature speed meter.
interface quad_speed_meter_if #(
    parameter int unsigned POS_W = 32,
    parameter int unsigned PER_W = 26
);
    logic             A;
    logic             B;
    logic             clr;
    logic [POS_W-1:0] pos;
    logic             dir;
    logic [PER_W-1:0] period;
    logic             period_valid;
    logic             stalled;
    logic             err;

    modport master (
        output A, B, clr,
        input  pos, dir, period, period_valid, stalled, err
    );

    modport slave (
        input  A, B, clr,
        output pos, dir, period, period_valid, stalled, err
    );
endinterface

// File: rtl/quad_speed_meter.sv
// x4 quadrature decoder with signed position, direction, edge-to-edge period
// measurement, stall detection and sticky illegal-transition flag.
module quad_speed_meter #(
    parameter int unsigned     POS_W   = 32,
    parameter int unsigned     PER_W   = 26,
    parameter logic [PER_W-1:0] TIMEOUT = 26'h3FFFFFF
) (
    input  logic              clk,
    input  logic              rst,
    quad_speed_meter_if.slave bus
);
    localparam logic [PER_W-1:0] PER_MAX = {PER_W{1'b1}};

    typedef enum logic [1:0] {INIT, ARMED, TRACK} state_t;

    state_t           state, state_nxt;
    logic             a_s1, a_s2, b_s1, b_s2;
    logic [1:0]       p;
    logic [1:0]       init_cnt;
    logic [PER_W-1:0] per_cnt, per_cnt_nxt;

    logic [POS_W-1:0] pos_q, pos_nxt;
    logic             dir_q, dir_nxt;
    logic [PER_W-1:0] period_q, period_nxt;
    logic             pv_q, pv_nxt;
    logic             stalled_q, stalled_nxt;
    logic             err_q, err_nxt;

    logic [1:0] s;
    logic [1:0] diff;
    logic       decode;
    logic       legal;
    logic       illegal;
    logic       fwd;

    assign s       = {a_s2, b_s2};
    assign diff    = s ^ p;
    assign decode  = (state != INIT);
    assign legal   = decode && (diff == 2'b01 || diff == 2'b10);
    assign illegal = decode && (diff == 2'b11);
    // Forward Gray order 00->01->11->10->00 reduces to p[1] != s[0]
    assign fwd     = p[1] ^ s[0];

    // Two-flop synchronisers and previous-state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_s1 <= 1'b0;
            a_s2 <= 1'b0;
            b_s1 <= 1'b0;
            b_s2 <= 1'b0;
            p    <= 2'b00;
        end else begin
            a_s1 <= bus.A;
            a_s2 <= a_s1;
            b_s1 <= bus.B;
            b_s2 <= b_s1;
            p    <= s;
        end
    end

    // State register; INIT holds until the cleared synchronisers carry real A/B
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= INIT;
            init_cnt <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == INIT && init_cnt != 2'd2)
                init_cnt <= init_cnt + 2'd1;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            INIT:    if (init_cnt == 2'd2) state_nxt = ARMED;
            ARMED:   if (legal) state_nxt = TRACK;
            TRACK: begin
                if (illegal)                state_nxt = ARMED;
                else if (!legal && per_cnt >= TIMEOUT) state_nxt = ARMED;
            end
            default: state_nxt = INIT;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        pos_nxt     = pos_q;
        dir_nxt     = dir_q;
        period_nxt  = period_q;
        pv_nxt      = 1'b0;
        stalled_nxt = stalled_q;
        err_nxt     = err_q;
        per_cnt_nxt = (per_cnt == PER_MAX) ? per_cnt : per_cnt + PER_W'(1);

        if (illegal) begin
            err_nxt = 1'b1;
        end else if (legal) begin
            per_cnt_nxt = PER_W'(1);
            pos_nxt     = fwd ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
            dir_nxt     = fwd;
            stalled_nxt = 1'b0;
            if (state == TRACK && fwd == dir_q) begin
                period_nxt = per_cnt;
                pv_nxt     = 1'b1;
            end
        end else if (state == TRACK && per_cnt >= TIMEOUT) begin
            stalled_nxt = 1'b1;
        end

        if (bus.clr) begin
            pos_nxt = '0;
            err_nxt = 1'b0;
        end
    end

    // Registered outputs and interval counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q     <= '0;
            dir_q     <= 1'b1;
            period_q  <= '0;
            pv_q      <= 1'b0;
            stalled_q <= 1'b0;
            err_q     <= 1'b0;
            per_cnt   <= '0;
        end else begin
            pos_q     <= pos_nxt;
            dir_q     <= dir_nxt;
            period_q  <= period_nxt;
            pv_q      <= pv_nxt;
            stalled_q <= stalled_nxt;
            err_q     <= err_nxt;
            per_cnt   <= per_cnt_nxt;
        end
    end

    assign bus.pos          = pos_q;
    assign bus.dir          = dir_q;
    assign bus.period       = period_q;
    assign bus.period_valid = pv_q;
    assign bus.stalled      = stalled_q;
    assign bus.err          = err_q;
endmodule
